// File: rtl/lcfg_cfgi_target.sv
// Config-bus target: decodes a base/mask window and serializes each 32-bit
// access into four byte-wide strobed accesses on the local register bus.
module lcfg_cfgi_target #(
    parameter logic [15:0] cfg_base    = 16'h0000,
    parameter logic [15:0] cfg_mask    = 16'hFF00,
    parameter int unsigned ack_timeout = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfgi_irdy,
    input  logic [15:0] cfgi_addr,
    input  logic        cfgi_write,
    input  logic [31:0] cfgi_wr_data,
    output logic        cfgi_trdy,
    output logic [31:0] cfgi_rd_data,
    output logic [9:0]  lcl_addr,
    output logic        lcl_wr_stb,
    output logic        lcl_rd_stb,
    output logic [7:0]  lcl_wr_data,
    input  logic [7:0]  lcl_rd_data,
    input  logic        lcl_ack,
    input  logic        err_clr,
    output logic        timeout_err
);

    typedef enum logic [2:0] {S_IDLE, S_BYTE, S_GAP, S_DONE, S_TURN} state_e;

    // Last BYTE-cycle count value before a forced completion.
    localparam logic [7:0] TMO_LAST = 8'(ack_timeout - 1);

    state_e      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic hit;
    logic byte_done;
    logic tmo;

    assign hit = (cfgi_addr & cfg_mask) == cfg_base;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        byte_done = 1'b0;
        tmo       = 1'b0;

        // A clear in the same cycle as a timeout loses: the set below overrides.
        if (err_clr) err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cfgi_irdy && hit) begin
                    addr_d  = cfgi_addr[7:0];
                    write_d = cfgi_write;
                    wdata_d = cfgi_wr_data;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    state_d = S_BYTE;
                end
            end
            S_BYTE: begin
                if (lcl_ack) begin
                    byte_done = 1'b1;
                end else if (cnt_q == TMO_LAST) begin
                    byte_done = 1'b1;
                    tmo       = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (byte_done) begin
                    cnt_d = '0;
                    if (!write_q) rdata_d[{idx_q, 3'b000} +: 8] = tmo ? 8'hFF : lcl_rd_data;
                    if (tmo) err_d = 1'b1;
                    if (idx_q == 2'd3) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP:   state_d = S_BYTE;
            S_DONE:  state_d = S_TURN;
            S_TURN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign cfgi_trdy    = (state_q == S_DONE);
    assign cfgi_rd_data = rdata_q;
    assign lcl_addr     = {addr_q, idx_q};
    assign lcl_wr_stb   = (state_q == S_BYTE) && write_q;
    assign lcl_rd_stb   = (state_q == S_BYTE) && !write_q;
    assign lcl_wr_data  = wdata_q[{idx_q, 3'b000} +: 8];
    assign timeout_err  = err_q;

endmodule

// File: tb/tb_lcfg_cfgi_target.sv
// Directed bench for lcfg_cfgi_target: a default-parameter instance plus a
// short-timeout instance, sharing one local-bus ack/read-data model.
module tb_lcfg_cfgi_target;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        irdy = 1'b0;
    logic [15:0] addr = '0;
    logic        wr = 1'b0;
    logic [31:0] wdata = '0;
    logic        err_clr = 1'b0;
    logic        sel_t = 1'b0;
    logic        lcl_ack;
    logic [7:0]  lcl_rd_data;

    logic        m_trdy, t_trdy, m_wstb, t_wstb, m_rstb, t_rstb, m_err, t_err;
    logic [31:0] m_rd, t_rd;
    logic [9:0]  m_addr, t_addr;
    logic [7:0]  m_wd, t_wd;

    int ntests = 0;
    int nfail  = 0;

    lcfg_cfgi_target u_m (
        .clk(clk), .reset(reset), .cfgi_irdy(irdy & ~sel_t), .cfgi_addr(addr),
        .cfgi_write(wr), .cfgi_wr_data(wdata), .cfgi_trdy(m_trdy), .cfgi_rd_data(m_rd),
        .lcl_addr(m_addr), .lcl_wr_stb(m_wstb), .lcl_rd_stb(m_rstb), .lcl_wr_data(m_wd),
        .lcl_rd_data(lcl_rd_data), .lcl_ack(lcl_ack), .err_clr(err_clr), .timeout_err(m_err)
    );

    lcfg_cfgi_target #(.ack_timeout(4)) u_t (
        .clk(clk), .reset(reset), .cfgi_irdy(irdy & sel_t), .cfgi_addr(addr),
        .cfgi_write(wr), .cfgi_wr_data(wdata), .cfgi_trdy(t_trdy), .cfgi_rd_data(t_rd),
        .lcl_addr(t_addr), .lcl_wr_stb(t_wstb), .lcl_rd_stb(t_rstb), .lcl_wr_data(t_wd),
        .lcl_rd_data(lcl_rd_data), .lcl_ack(lcl_ack), .err_clr(err_clr), .timeout_err(t_err)
    );

    always #5 clk = ~clk;

    // Selected-instance view and the local peripheral model.
    logic        stb_s, wstb_s, trdy_s;
    logic [9:0]  addr_s;
    logic [7:0]  wd_s;
    logic [31:0] rd_s;
    logic [7:0]  rd_bytes [4];
    int          ack_wait = 0;
    logic        nack_en = 1'b0;
    logic [1:0]  nack_idx = 2'd0;
    int          wait_cnt = 0;

    assign wstb_s = sel_t ? t_wstb : m_wstb;
    assign stb_s  = sel_t ? (t_wstb | t_rstb) : (m_wstb | m_rstb);
    assign trdy_s = sel_t ? t_trdy : m_trdy;
    assign addr_s = sel_t ? t_addr : m_addr;
    assign wd_s   = sel_t ? t_wd : m_wd;
    assign rd_s   = sel_t ? t_rd : m_rd;
    assign lcl_rd_data = rd_bytes[addr_s[1:0]];
    assign lcl_ack = stb_s && (wait_cnt >= ack_wait) && !(nack_en && addr_s[1:0] == nack_idx);

    // Monotonic event logs; the directed sequence snapshots counts around each step.
    logic        stb_prev = 1'b0;
    int          rise_cnt = 0, stb_cyc = 0, wr_cnt = 0;
    logic [9:0]  rise_addr [64];
    logic [17:0] wr_log [64];

    always @(posedge clk) begin
        wait_cnt <= stb_s ? wait_cnt + 1 : 0;
        stb_prev <= stb_s;
        if (stb_s) stb_cyc <= stb_cyc + 1;
        if (stb_s && !stb_prev) begin
            rise_addr[rise_cnt[5:0]] <= addr_s;
            rise_cnt <= rise_cnt + 1;
        end
        if (wstb_s && lcl_ack) begin
            wr_log[wr_cnt[5:0]] <= {addr_s, wd_s};
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_trdy(input int budget, output int lat, output logic [31:0] rd);
        lat = -1;
        rd  = 'x;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (trdy_s) begin
                lat = k;
                rd  = rd_s;
                break;
            end
        end
    endtask

    task automatic do_txn(input logic [15:0] a, input logic w, input logic [31:0] d,
                          output int lat, output logic [31:0] rd);
        @(negedge clk);
        addr = a; wr = w; wdata = d; irdy = 1'b1;
        wait_trdy(400, lat, rd);
        @(negedge clk);
        irdy = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, s0, s1, cnt, t1, t2, fb;
        logic [31:0] rd;

        rd_bytes[0] = 8'h00; rd_bytes[1] = 8'h00; rd_bytes[2] = 8'h00; rd_bytes[3] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_trdy", {31'b0, m_trdy}, 32'd0);
        chk("rst_rd", m_rd, 32'd0);
        chk("rst_stb", {30'b0, m_wstb, m_rstb}, 32'd0);
        chk("rst_addr", {22'b0, m_addr}, 32'd0);
        chk("rst_wd", {24'b0, m_wd}, 32'd0);
        chk("rst_err", {31'b0, m_err}, 32'd0);

        // Zero-wait write 0x11223344 to 0x0005.
        s0 = wr_cnt;
        do_txn(16'h0005, 1'b1, 32'h1122_3344, lat, rd);
        chk("wr_lat", lat, 32'd8);
        chk("wr_nbytes", wr_cnt - s0, 32'd4);
        chk("wr_b0", {14'b0, wr_log[(s0 + 0) % 64]}, {14'b0, 10'h014, 8'h44});
        chk("wr_b1", {14'b0, wr_log[(s0 + 1) % 64]}, {14'b0, 10'h015, 8'h33});
        chk("wr_b2", {14'b0, wr_log[(s0 + 2) % 64]}, {14'b0, 10'h016, 8'h22});
        chk("wr_b3", {14'b0, wr_log[(s0 + 3) % 64]}, {14'b0, 10'h017, 8'h11});
        chk("wr_rd_hold", rd, 32'd0);

        // Read with ack on the third strobe cycle of each byte.
        ack_wait = 2;
        rd_bytes[0] = 8'hEF; rd_bytes[1] = 8'hBE; rd_bytes[2] = 8'hAD; rd_bytes[3] = 8'hDE;
        s0 = rise_cnt;
        do_txn(16'h00A0, 1'b0, 32'h0, lat, rd);
        chk("rd_lat", lat, 32'd16);
        chk("rd_data", rd, 32'hDEAD_BEEF);
        chk("rd_rises", rise_cnt - s0, 32'd4);
        chk("rd_rise0", {22'b0, rise_addr[(s0 + 0) % 64]}, 32'h280);
        chk("rd_rise3", {22'b0, rise_addr[(s0 + 3) % 64]}, 32'h283);
        ack_wait = 0;

        // Out-of-window request held for 300 cycles.
        @(negedge clk);
        s0 = stb_cyc; cnt = 0;
        addr = 16'h0105; wr = 1'b1; wdata = 32'hFFFF_FFFF; irdy = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (m_trdy) cnt++;
        end
        irdy = 1'b0;
        chk("miss_trdy", cnt, 32'd0);
        chk("miss_stb", stb_cyc - s0, 32'd0);
        do_txn(16'h0001, 1'b0, 32'h0, lat, rd);
        chk("miss_then_lat", lat, 32'd8);

        // Short-timeout instance, byte 2 never acked.
        sel_t = 1'b1; nack_en = 1'b1; nack_idx = 2'd2;
        rd_bytes[0] = 8'h01; rd_bytes[1] = 8'h02; rd_bytes[2] = 8'h03; rd_bytes[3] = 8'h04;
        do_txn(16'h0003, 1'b0, 32'h0, lat, rd);
        chk("tmo_lat", lat, 32'd11);
        chk("tmo_data", rd, 32'h04FF_0201);
        chk("tmo_err_set", {31'b0, t_err}, 32'd1);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        chk("tmo_clr", {31'b0, t_err}, 32'd0);

        // Clear coincides with the timeout cycle (N+8): set must win.
        @(negedge clk);
        addr = 16'h0003; wr = 1'b0; irdy = 1'b1;
        repeat (8) @(negedge clk);
        chk("tmo2_pre", {31'b0, t_err}, 32'd0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("tmo2_setwins", {31'b0, t_err}, 32'd1);
        wait_trdy(50, lat, rd);
        chk("tmo2_lat", lat, 32'd2);
        chk("tmo2_data", rd, 32'h04FF_0201);
        @(negedge clk); irdy = 1'b0; err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        chk("tmo2_clr", {31'b0, t_err}, 32'd0);
        nack_en = 1'b0;
        @(negedge clk); sel_t = 1'b0;

        // Reset asserted during BYTE1 of a read.
        @(negedge clk);
        addr = 16'h0040; wr = 1'b0; irdy = 1'b1;
        repeat (3) @(negedge clk);
        chk("rstm_stb", {31'b0, m_rstb}, 32'd1);
        chk("rstm_addr", {22'b0, m_addr}, 32'h101);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; irdy = 1'b0;
        chk("rstm_stb_off", {30'b0, m_wstb, m_rstb}, 32'd0);
        chk("rstm_rd", m_rd, 32'd0);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (m_trdy) cnt++;
        end
        chk("rstm_notrdy", cnt, 32'd0);
        rd_bytes[0] = 8'h55; rd_bytes[1] = 8'h66; rd_bytes[2] = 8'h77; rd_bytes[3] = 8'h88;
        do_txn(16'h0010, 1'b0, 32'h0, lat, rd);
        chk("rstm_next_lat", lat, 32'd8);
        chk("rstm_next_data", rd, 32'h8877_6655);

        // Back-to-back: irdy stays high, second request presented at first trdy.
        rd_bytes[0] = 8'h12; rd_bytes[1] = 8'h34; rd_bytes[2] = 8'h56; rd_bytes[3] = 8'h78;
        @(negedge clk);
        addr = 16'h0030; wr = 1'b1; wdata = 32'hCAFE_F00D; irdy = 1'b1;
        t1 = -1; t2 = -1; fb = -1; rd = 'x;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (t1 > 0 && fb < 0 && m_rstb) fb = k;
            if (m_trdy) begin
                if (t1 < 0) begin
                    t1 = k;
                    addr = 16'h0031; wr = 1'b0;
                end else begin
                    t2 = k;
                    rd = m_rd;
                    break;
                end
            end
        end
        @(negedge clk); irdy = 1'b0;
        chk("b2b_t1", t1, 32'd8);
        chk("b2b_first_byte", fb, 32'd11);
        chk("b2b_t2", t2, 32'd18);
        chk("b2b_data", rd, 32'h7856_3412);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
